// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl
// ---------------
// Pipeline control unit for an in-order core. It keeps a small record for
// each stage: valid, rd, rd write-enable and is-load. Stage 0 is decode and
// stage NUM_STAGES-1 is writeback. The block detects read-after-write hazards
// for the instruction in decode. On a hazard it holds decode and puts a bubble
// into stage 1. On a mispredict resolved in stage 1 it kills the younger work.
// It also keeps saturating counters for retired instructions and stall cycles.
//
// Parameters
//   NUM_STAGES  pipeline depth including decode and writeback (3..8)
//   REG_AW      register address width
//   FWD_EN      1: full forwarding, so only a load-use pair stalls;
//               0: no forwarding, so any RAW match in stages 1..N-2 stalls
//   CNT_W       width of the performance counters
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid        fetch offers a decoded instruction
//   in_ready        the instruction is accepted into stage 0 this cycle
//   in_rs1, in_rs2  source registers (x0 means no dependency)
//   in_rd, in_rd_we destination register and its write enable
//   in_is_load      instruction is a load (result ready at stage 2)
//   flush_req       mispredict resolved in stage 1: kill stage 0 and its input
//   stage_valid     valid bit of each stage register
//   stage_adv       stage k moves to k+1 this cycle (top bit = retire)
//   stall           decode held, bubble injected into stage 1
//   retire_valid    writeback stage holds a valid instruction
//   retire_rd       rd of the retiring instruction (0 when it writes nothing)
//   retire_cnt      saturating count of retired instructions
//   stall_cnt       saturating count of stall cycles
//
// Handshake: in_valid/in_ready is a zero-cycle handshake. The instruction is
// taken on the rising edge that ends a cycle in which in_valid and in_ready
// are both high. in_ready does not depend on in_valid. Fetch must keep an
// instruction that was not accepted stable until it is accepted.

module riscv_pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic                  in_rd_we,
  input  logic                  in_is_load,
  input  logic                  flush_req,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] stage_adv,
  output logic                  stall,
  output logic                  retire_valid,
  output logic [REG_AW-1:0]     retire_rd,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Per-stage bookkeeping. Only decode needs its source registers.
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] we_q;
  logic [NUM_STAGES-1:0] ld_q;
  logic [REG_AW-1:0]     rd_q [NUM_STAGES];
  logic [REG_AW-1:0]     rs1_q;
  logic [REG_AW-1:0]     rs2_q;
  logic [CNT_W-1:0]      retire_cnt_q;
  logic [CNT_W-1:0]      stall_cnt_q;

  // The load flag of the writeback stage has no consumer.
  logic unused_wb_ld;
  assign unused_wb_ld = ld_q[NUM_STAGES-1];

  logic              hazard;
  logic              stall_int;
  logic              accept;
  logic              in_we_eff;
  logic [REG_AW-1:0] in_rd_eff;

  // Next values for stage 0 and for the incoming side of stage 1.
  logic              s0_valid_d;
  logic              s0_we_d;
  logic              s0_ld_d;
  logic [REG_AW-1:0] s0_rd_d;
  logic [REG_AW-1:0] s0_rs1_d;
  logic [REG_AW-1:0] s0_rs2_d;
  logic              s1_valid_d;
  logic              s1_we_d;
  logic              s1_ld_d;
  logic [REG_AW-1:0] s1_rd_d;

  // A write to x0 is not a write. The stored rd is forced to 0 so that x0
  // never matches and retire_rd reads 0.
  assign in_we_eff = in_rd_we & (in_rd != '0);
  assign in_rd_eff = in_we_eff ? in_rd : '0;

  // Hazard detection against the sources held in decode.
  // With forwarding, only a load one stage ahead is not yet forwardable.
  // Without forwarding, every producer in stages 1..N-2 blocks. Writeback is
  // left out because the register file writes before it reads in the same
  // cycle.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = valid_q[1] & we_q[1] & ld_q[1] & (rd_q[1] != '0) &
               ((rd_q[1] == rs1_q) | (rd_q[1] == rs2_q));
    end else begin
      for (int k = 1; k < NUM_STAGES - 1; k++) begin
        if (valid_q[k] && we_q[k] && (rd_q[k] != '0) &&
            ((rd_q[k] == rs1_q) || (rd_q[k] == rs2_q))) begin
          hazard = 1'b1;
        end
      end
    end
  end

  // Flush wins over stall. A flushed cycle is never a stall cycle.
  assign stall_int = valid_q[0] & hazard & ~flush_req;
  assign in_ready  = ~flush_req & ~stall_int;
  assign accept    = in_valid & in_ready;

  // Decode stage next state.
  always_comb begin
    s0_valid_d = valid_q[0];
    s0_we_d    = we_q[0];
    s0_ld_d    = ld_q[0];
    s0_rd_d    = rd_q[0];
    s0_rs1_d   = rs1_q;
    s0_rs2_d   = rs2_q;
    if (flush_req) begin
      s0_valid_d = 1'b0;
      s0_we_d    = 1'b0;
      s0_ld_d    = 1'b0;
      s0_rd_d    = '0;
      s0_rs1_d   = '0;
      s0_rs2_d   = '0;
    end else if (stall_int) begin
      // Hold: the defaults above keep the current contents.
    end else if (accept) begin
      s0_valid_d = 1'b1;
      s0_we_d    = in_we_eff;
      s0_ld_d    = in_is_load;
      s0_rd_d    = in_rd_eff;
      s0_rs1_d   = in_rs1;
      s0_rs2_d   = in_rs2;
    end else begin
      s0_valid_d = 1'b0;
      s0_we_d    = 1'b0;
      s0_ld_d    = 1'b0;
      s0_rd_d    = '0;
      s0_rs1_d   = '0;
      s0_rs2_d   = '0;
    end
  end

  // Stage 1 gets a bubble on flush (younger work is dead) or on stall
  // (decode is held). Otherwise it takes the decode contents.
  always_comb begin
    s1_valid_d = 1'b0;
    s1_we_d    = 1'b0;
    s1_ld_d    = 1'b0;
    s1_rd_d    = '0;
    if (!flush_req && !stall_int) begin
      s1_valid_d = valid_q[0];
      s1_we_d    = we_q[0];
      s1_ld_d    = ld_q[0];
      s1_rd_d    = rd_q[0];
    end
  end

  // Stage registers and counters. Stages 1..N-1 always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      we_q         <= '0;
      ld_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= s0_valid_d;
      we_q[0]    <= s0_we_d;
      ld_q[0]    <= s0_ld_d;
      rd_q[0]    <= s0_rd_d;
      rs1_q      <= s0_rs1_d;
      rs2_q      <= s0_rs2_d;

      valid_q[1] <= s1_valid_d;
      we_q[1]    <= s1_we_d;
      ld_q[1]    <= s1_ld_d;
      rd_q[1]    <= s1_rd_d;

      for (int k = 2; k < NUM_STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        ld_q[k]    <= ld_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end

      if (valid_q[NUM_STAGES-1] && (retire_cnt_q != CNT_MAX)) begin
        retire_cnt_q <= retire_cnt_q + CNT_ONE;
      end
      if (stall_int && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

  // Stage 0 advances only when it is not held or killed. Stages 1..N-1
  // always advance.
  always_comb begin
    stage_adv    = valid_q;
    stage_adv[0] = valid_q[0] & ~stall_int & ~flush_req;
  end

  assign stage_valid  = valid_q;
  assign stall        = stall_int;
  assign retire_valid = valid_q[NUM_STAGES-1];
  assign retire_rd    = we_q[NUM_STAGES-1] ? rd_q[NUM_STAGES-1] : '0;
  assign retire_cnt   = retire_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed testbench for riscv_pipe_ctrl.
// Three instances share the operand inputs and each one has its own in_valid:
//   u_a : NUM_STAGES=5, FWD_EN=1, CNT_W=32
//   u_b : NUM_STAGES=5, FWD_EN=0, CNT_W=32
//   u_c : NUM_STAGES=5, FWD_EN=1, CNT_W=4  (counter saturation)
// Inputs are driven 1 ns after the rising edge. Outputs are checked 2 ns
// after the rising edge.

module tb_riscv_pipe_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       iv_a, iv_b, iv_c;
  logic [4:0] rs1, rs2, rd;
  logic       rd_we, is_load, flush;
  int         tgt;

  // ---------------- DUT outputs ----------------
  logic       a_in_ready, b_in_ready, c_in_ready;
  logic [4:0] a_sv, b_sv, c_sv;
  logic [4:0] a_adv, b_adv, c_adv;
  logic       a_stall, b_stall, c_stall;
  logic       a_rv, b_rv, c_rv;
  logic [4:0] a_rrd, b_rrd, c_rrd;
  logic [31:0] a_rcnt, a_scnt, b_rcnt, b_scnt;
  logic [3:0]  c_rcnt, c_scnt;

  riscv_pipe_ctrl #(.NUM_STAGES(5), .REG_AW(5), .FWD_EN(1), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(a_in_ready),
    .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd), .in_rd_we(rd_we),
    .in_is_load(is_load), .flush_req(flush), .stage_valid(a_sv),
    .stage_adv(a_adv), .stall(a_stall), .retire_valid(a_rv),
    .retire_rd(a_rrd), .retire_cnt(a_rcnt), .stall_cnt(a_scnt)
  );

  riscv_pipe_ctrl #(.NUM_STAGES(5), .REG_AW(5), .FWD_EN(0), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(b_in_ready),
    .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd), .in_rd_we(rd_we),
    .in_is_load(is_load), .flush_req(flush), .stage_valid(b_sv),
    .stage_adv(b_adv), .stall(b_stall), .retire_valid(b_rv),
    .retire_rd(b_rrd), .retire_cnt(b_rcnt), .stall_cnt(b_scnt)
  );

  riscv_pipe_ctrl #(.NUM_STAGES(5), .REG_AW(5), .FWD_EN(1), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(c_in_ready),
    .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd), .in_rd_we(rd_we),
    .in_is_load(is_load), .flush_req(flush), .stage_valid(c_sv),
    .stage_adv(c_adv), .stall(c_stall), .retire_valid(c_rv),
    .retire_rd(c_rrd), .retire_cnt(c_rcnt), .stall_cnt(c_scnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic we, input logic ld);
    iv_a    = v && (tgt == 0);
    iv_b    = v && (tgt == 1);
    iv_c    = v && (tgt == 2);
    rs1     = s1;
    rs2     = s2;
    rd      = d;
    rd_we   = we;
    is_load = ld;
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    tgt   = 0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    // Reset state
    check("rst_stage_valid", 32'(a_sv), 32'd0);
    check("rst_retire_cnt", a_rcnt, 32'd0);
    check("rst_stall_cnt", a_scnt, 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_stall", 32'(a_stall), 32'd0);
    check("rst_c_retire_cnt", 32'(c_rcnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ten independent instructions on u_a. Instruction i is accepted at the
    // end of cycle i and is in writeback during cycle i+5.
    tgt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      set_in(c < 10, 5'(21 + c), 5'd0, 5'(c + 1), 1'b1, 1'b0);
      #1;
      check("stream_in_ready", 32'(a_in_ready), 32'd1);
      check("stream_stall", 32'(a_stall), 32'd0);
      check("stream_retire_valid", 32'(a_rv), 32'(c >= 5 && c <= 14));
      check("stream_adv", 32'(a_adv), 32'(a_sv));
      if (c >= 5 && c <= 14) check("stream_retire_rd", 32'(a_rrd), 32'(c - 4));
    end
    check("stream_retire_cnt", a_rcnt, 32'd10);
    check("stream_stall_cnt", a_scnt, 32'd0);

    // Reset in the middle of a stream
    for (int c = 0; c < 3; c++) begin
      tick();
      set_in(1'b1, 5'd0, 5'd0, 5'(c + 1), 1'b1, 1'b0);
    end
    tick();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("midrst_pre_valid", 32'(a_sv), 32'b00111);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_stage_valid", 32'(a_sv), 32'd0);
    check("midrst_retire_cnt", a_rcnt, 32'd0);
    check("midrst_in_ready", 32'(a_in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use with forwarding (u_a): a load to x5, then an add that reads x5
    tgt = 0;
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    #1;
    check("ldu_c1_stall", 32'(a_stall), 32'd0);
    tick();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("ldu_c2_stall", 32'(a_stall), 32'd1);
    check("ldu_c2_in_ready", 32'(a_in_ready), 32'd0);
    check("ldu_c2_adv", 32'(a_adv), 32'b00010);
    tick();
    #1;
    check("ldu_c3_stall", 32'(a_stall), 32'd0);
    check("ldu_c3_bubble", 32'(a_sv), 32'b00101);
    check("ldu_c3_stall_cnt", a_scnt, 32'd1);
    tick();
    #1;
    check("ldu_c4_valid", 32'(a_sv), 32'b01010);
    check("ldu_c4_stall_cnt", a_scnt, 32'd1);

    // No forwarding (u_b): add x3, then sub rs2=x3 stalls for 3 cycles
    tgt = 1;
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    #1;
    check("nofwd_c0_stall", 32'(b_stall), 32'd0);
    tick();
    set_in(1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0);
    #1;
    check("nofwd_c1_in_ready", 32'(b_in_ready), 32'd1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      check("nofwd_stall", 32'(b_stall), 32'(c < 5));
    end
    check("nofwd_stall_cnt", b_scnt, 32'd3);
    check("nofwd_c5_valid", 32'(b_sv), 32'b10001);
    for (int c = 0; c < 6; c++) tick();

    // x0 destination, x0 sources, and a non-writing producer never stall
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);   // A: rd=x0, we=1
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);   // B: rs1=rs2=x0
    #1;
    check("x0_b_stall", 32'(b_stall), 32'd0);
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0);  // C: rd=x11, we=0
    #1;
    check("x0_c_stall", 32'(b_stall), 32'd0);
    tick();
    set_in(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0); // D: rs1=x11
    #1;
    check("x0_d_stall", 32'(b_stall), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      check("x0_tail_stall", 32'(b_stall), 32'd0);
    end
    check("x0_stall_cnt", b_scnt, 32'd3);
    for (int c = 0; c < 6; c++) tick();

    // Flush while a load-use hazard is pending in decode (u_a)
    tgt = 0;
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(a_stall), 32'd0);
    check("flush_in_ready", 32'(a_in_ready), 32'd0);
    check("flush_adv", 32'(a_adv), 32'b00010);
    tick();
    flush = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("flush_after_valid", 32'(a_sv), 32'b00100);
    check("flush_stall_cnt", a_scnt, 32'd1);

    // Saturation of a 4-bit retire counter (u_c)
    tgt = 2;
    for (int c = 0; c < 26; c++) begin
      tick();
      set_in(c < 20, 5'd0, 5'd0, 5'(c + 1), 1'b1, 1'b0);
      #1;
      if (c == 20) check("sat_cnt_at_15", 32'(c_rcnt), 32'd15);
    end
    check("sat_cnt_final", 32'(c_rcnt), 32'd15);
    check("sat_retire_idle", 32'(c_rv), 32'd0);
    check("sat_stall_cnt", 32'(c_scnt), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
